// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C slave register bank: FSM encoding, ACK levels, bit counter sizing.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_t;

  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  // Counts received bits 0..8 so a completed byte is distinguishable from an empty one.
  localparam int                   BIT_CNT_W     = 4;
  localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = 4'd8;
  localparam logic [BIT_CNT_W-1:0] LAST_TX_BIT   = 4'd7;

endpackage

// File: rtl/i2c_pin_sync.sv
// Two-flop synchronisers on SCL/SDA plus a history flop; emits single-clk SCL edge and START/STOP pulses.
module i2c_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [0] metastable stage, [1] synchronised value, [2] previous synchronised value
  logic [2:0] scl_sr;
  logic [2:0] sda_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      scl_sr <= {scl_sr[1:0], scl_i};
      sda_sr <= {sda_sr[1:0], sda_i};
    end
  end

  assign sda      = sda_sr[1];
  assign scl_rise = scl_sr[1] & ~scl_sr[2];
  assign scl_fall = ~scl_sr[1] & scl_sr[2];
  assign start    = scl_sr[1] & scl_sr[2] & sda_sr[2] & ~sda_sr[1];
  assign stop     = scl_sr[1] & scl_sr[2] & ~sda_sr[2] & sda_sr[1];

endmodule

// File: rtl/i2c_slave_regbank.sv
// I2C slave with a NUM_REGS x 8-bit register bank, auto-incrementing pointer and per-write strobe.
// Fully synchronous to clk; SDA output changes only after a detected SCL fall.
module i2c_slave_regbank
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] I2C_ADR   = 7'h27,
  parameter int         NUM_REGS  = 8,
  parameter int         PTR_W     = 3,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] reg_out,
  output logic                  wr_stb,
  output logic [PTR_W-1:0]      wr_idx,
  output logic                  busy
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_pin_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t               state, state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, cnt_nxt;
  logic [7:0]           shift, shift_nxt;
  logic [PTR_W-1:0]     ptr, ptr_nxt;
  logic                 oe_nxt, busy_nxt;
  logic                 rw, rw_nxt;
  logic                 ack_seen, ack_nxt;
  logic                 wr_en;
  logic [PTR_W-1:0]     wr_idx_nxt;
  logic [7:0]           regs [NUM_REGS];

  logic                 byte_done, addr_hit, rx_state;
  logic [PTR_W-1:0]     ptr_inc;
  logic [7:0]           rd_byte;

  assign byte_done = (bit_cnt == BITS_PER_BYTE);
  // General call (address 0) is never acknowledged.
  assign addr_hit  = (shift[7:1] == I2C_ADR) && (shift[7:1] != 7'd0);
  assign rx_state  = (state == ST_ADDR) || (state == ST_PTR) || (state == ST_WDATA);
  assign ptr_inc   = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + PTR_W'(1);
  assign rd_byte   = regs[ptr];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = bit_cnt;
    shift_nxt  = shift;
    ptr_nxt    = ptr;
    oe_nxt     = sda_oe;
    busy_nxt   = busy;
    rw_nxt     = rw;
    ack_nxt    = ack_seen;
    wr_en      = 1'b0;
    wr_idx_nxt = wr_idx;

    // START/STOP take priority over any coincident SCL edge; partial bytes are dropped.
    if (start) begin
      state_nxt = ST_ADDR;
      cnt_nxt   = '0;
      oe_nxt    = 1'b0;
      ack_nxt   = 1'b0;
    end else if (stop) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
      ack_nxt   = 1'b0;
    end else begin
      if (scl_rise && rx_state && !byte_done) begin
        shift_nxt = {shift[6:0], sda};
        cnt_nxt   = bit_cnt + BIT_CNT_W'(1);
      end

      unique case (state)
        ST_ADDR: if (scl_fall && byte_done) begin
          cnt_nxt = '0;
          if (addr_hit) begin
            state_nxt = ST_ADDR_ACK;
            oe_nxt    = 1'b1;
            rw_nxt    = shift[0];
            busy_nxt  = 1'b1;
          end else begin
            state_nxt = ST_WAIT_STOP;
            busy_nxt  = 1'b0;
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          cnt_nxt = '0;
          if (rw) begin
            state_nxt = ST_RDATA;
            shift_nxt = rd_byte;
            oe_nxt    = ~rd_byte[7];
          end else begin
            state_nxt = ST_PTR;
            oe_nxt    = 1'b0;
          end
        end
        ST_PTR: if (scl_fall && byte_done) begin
          state_nxt = ST_PTR_ACK;
          oe_nxt    = 1'b1;
          cnt_nxt   = '0;
          ptr_nxt   = (int'(shift) < NUM_REGS) ? PTR_W'(shift) : '0;
        end
        ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
          state_nxt = ST_WDATA;
          oe_nxt    = 1'b0;
          cnt_nxt   = '0;
        end
        ST_WDATA: if (scl_fall && byte_done) begin
          state_nxt  = ST_WDATA_ACK;
          oe_nxt     = 1'b1;
          cnt_nxt    = '0;
          wr_en      = 1'b1;
          wr_idx_nxt = ptr;
          ptr_nxt    = ptr_inc;
        end
        ST_RDATA: if (scl_fall) begin
          if (bit_cnt == LAST_TX_BIT) begin
            state_nxt = ST_RD_ACK;
            oe_nxt    = 1'b0;
            cnt_nxt   = '0;
          end else begin
            shift_nxt = {shift[6:0], 1'b0};
            oe_nxt    = ~shift[6];
            cnt_nxt   = bit_cnt + BIT_CNT_W'(1);
          end
        end
        ST_RD_ACK: begin
          // Pointer advances at the ACK sample; the next byte is driven after the following fall.
          if (scl_rise) begin
            if (sda == SDA_ACK) begin
              ptr_nxt = ptr_inc;
              ack_nxt = 1'b1;
            end else begin
              state_nxt = ST_WAIT_STOP;
            end
          end else if (scl_fall && ack_seen) begin
            state_nxt = ST_RDATA;
            shift_nxt = rd_byte;
            oe_nxt    = ~rd_byte[7];
            cnt_nxt   = '0;
            ack_nxt   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      shift    <= '0;
      ptr      <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
      ack_seen <= 1'b0;
      wr_stb   <= 1'b0;
      wr_idx   <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
    end else begin
      bit_cnt  <= cnt_nxt;
      shift    <= shift_nxt;
      ptr      <= ptr_nxt;
      sda_oe   <= oe_nxt;
      busy     <= busy_nxt;
      rw       <= rw_nxt;
      ack_seen <= ack_nxt;
      wr_stb   <= wr_en;
      wr_idx   <= wr_idx_nxt;
      if (wr_en) regs[ptr] <= shift;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign reg_out[8*k +: 8] = regs[k];
  end

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Bit-banged I2C master driving the register bank; ACKs, read bytes and write strobes are scoreboarded.
module tb_i2c_slave_regbank;

  localparam int Q = 5;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [63:0] reg_out;
  logic        wr_stb;
  logic [2:0]  wr_idx;
  logic        busy;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regbank dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_m),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .reg_out (reg_out),
    .wr_stb  (wr_stb),
    .wr_idx  (wr_idx),
    .busy    (busy)
  );

  int checks = 0;
  int errors = 0;

  logic        ack_q [$];
  logic [7:0]  rd_q  [$];
  logic [10:0] wr_q  [$];

  // Capture of DUT write strobes, consumed by the checking thread.
  logic [2:0] got_idx [64];
  logic [7:0] got_dat [64];
  int         got_cnt = 0;
  int         got_rd  = 0;
  int         oe_cnt  = 0;

  always @(negedge clk) begin
    if (wr_stb && got_cnt < 64) begin
      got_idx[got_cnt] <= wr_idx;
      got_dat[got_cnt] <= reg_out[int'(wr_idx)*8 +: 8];
      got_cnt <= got_cnt + 1;
    end
  end

  always @(posedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait(); qwait();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    qwait();
    scl_m = 1'b1; qwait(); qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic got;
    ack_q.push_back(exp_ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    got = ~sda_line; qwait();
    scl_m = 1'b0; qwait();
    chk(nm, 64'(got), 64'(ack_q.pop_front()));
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic m_ack, input string nm);
    logic [7:0] v;
    v = '0;
    rd_q.push_back(exp);
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      qwait();
      scl_m = 1'b1; qwait();
      v = {v[6:0], sda_line}; qwait();
      scl_m = 1'b0; qwait();
    end
    sda_m = ~m_ack; qwait();
    scl_m = 1'b1; qwait(); qwait();
    scl_m = 1'b0; qwait();
    sda_m = 1'b1;
    chk(nm, 64'(v), 64'(rd_q.pop_front()));
  endtask

  task automatic check_writes();
    logic [10:0] e;
    while (wr_q.size() > 0) begin
      e = wr_q.pop_front();
      if (got_rd < got_cnt) begin
        chk("wr_idx", 64'(got_idx[got_rd]), 64'(e[10:8]));
        chk("wr_dat", 64'(got_dat[got_rd]), 64'(e[7:0]));
        got_rd++;
      end else begin
        chk("wr_missing", 64'(got_cnt), 64'(got_rd + 1));
      end
    end
    chk("wr_extra", 64'(got_cnt), 64'(got_rd));
  endtask

  typedef struct {
    logic [7:0] adr;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack;
    logic [2:0] i0;
    logic [2:0] i1;
  } vec_t;

  initial begin
    vec_t        vecs [5];
    logic [63:0] exp_bank;
    int          oe0;

    vecs[0] = '{8'h4E, 8'h02, 8'hA5, 8'h5A, 1'b1, 3'd2, 3'd3};
    vecs[1] = '{8'h4E, 8'h07, 8'h11, 8'h22, 1'b1, 3'd7, 3'd0};  // pointer wrap
    vecs[2] = '{8'h4E, 8'h05, 8'hC3, 8'h3C, 1'b1, 3'd5, 3'd6};
    vecs[3] = '{8'h50, 8'hFF, 8'h12, 8'h34, 1'b0, 3'd0, 3'd0};  // foreign address
    vecs[4] = '{8'h4E, 8'h0A, 8'h77, 8'h88, 1'b1, 3'd0, 3'd1};  // out-of-range pointer -> 0
    exp_bank = '0;

    repeat (4) @(posedge clk);
    #1;
    chk("rst_sda_oe", 64'(sda_oe), 64'd0);
    chk("rst_busy",   64'(busy),   64'd0);
    chk("rst_wr_stb", 64'(wr_stb), 64'd0);
    chk("rst_wr_idx", 64'(wr_idx), 64'd0);
    chk("rst_regs",   reg_out,     64'd0);
    rst = 1'b0;
    qwait();

    for (int v = 0; v < 5; v++) begin
      oe0 = oe_cnt;
      i2c_start();
      send_byte(vecs[v].adr, vecs[v].ack, "addr_ack");
      chk("busy_addr", 64'(busy), 64'(vecs[v].ack));
      send_byte(vecs[v].ptr, vecs[v].ack, "ptr_ack");
      if (vecs[v].ack) begin
        wr_q.push_back({vecs[v].i0, vecs[v].d0});
        wr_q.push_back({vecs[v].i1, vecs[v].d1});
        exp_bank[int'(vecs[v].i0)*8 +: 8] = vecs[v].d0;
        exp_bank[int'(vecs[v].i1)*8 +: 8] = vecs[v].d1;
      end
      send_byte(vecs[v].d0, vecs[v].ack, "d0_ack");
      send_byte(vecs[v].d1, vecs[v].ack, "d1_ack");
      i2c_stop();
      chk("busy_stop", 64'(busy), 64'd0);
      chk("regs", reg_out, exp_bank);
      check_writes();
      if (!vecs[v].ack) chk("oe_foreign", 64'(oe_cnt - oe0), 64'd0);
    end

    // Set pointer, repeated start, read two bytes with ACK then NACK.
    i2c_start();
    send_byte(8'h4E, 1'b1, "rd_addr_w");
    send_byte(8'h02, 1'b1, "rd_ptr");
    i2c_start();
    send_byte(8'h4F, 1'b1, "rd_addr_r");
    chk("busy_read", 64'(busy), 64'd1);
    read_byte(8'hA5, 1'b1, "rd_byte0");
    read_byte(8'h5A, 1'b0, "rd_byte1");
    chk("nack_release", 64'(sda_oe), 64'd0);
    i2c_stop();
    check_writes();

    // Reset while driving a read bit low; pointer now 3 (0x5A, MSB 0 -> SDA pulled).
    i2c_start();
    send_byte(8'h4F, 1'b1, "rst_addr_r");
    chk("rd_drive", 64'(sda_oe), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_oe",   64'(sda_oe), 64'd0);
    chk("rst_mid_regs", reg_out,     64'd0);
    chk("rst_mid_busy", 64'(busy),   64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_bank = '0;
    i2c_stop();

    // Stop after four data bits: nothing written; the slave still serves the next transfer.
    i2c_start();
    send_byte(8'h4E, 1'b1, "part_addr");
    send_byte(8'h01, 1'b1, "part_ptr");
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    chk("part_busy", 64'(busy), 64'd0);
    chk("part_regs", reg_out, exp_bank);
    check_writes();
    i2c_start();
    send_byte(8'h4E, 1'b1, "post_addr");
    send_byte(8'h01, 1'b1, "post_ptr");
    wr_q.push_back({3'd1, 8'h99});
    exp_bank[15:8] = 8'h99;
    send_byte(8'h99, 1'b1, "post_data");
    i2c_stop();
    chk("post_regs", reg_out, exp_bank);
    check_writes();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
